// File: rtl/if_fetch_pkg.sv
// Shared definitions for the t1 instruction-fetch stage: datapath width,
// reset/bubble constants, the per-cycle fetch action and small helpers.
package if_fetch_pkg;

  localparam int                XLEN         = 32;
  localparam logic [XLEN-1:0]   RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0]   NOP_INST     = 32'h0000_0013;  // addi x0,x0,0

  // What the fetch stage does this cycle, in priority order.
  typedef enum logic [1:0] {
    ACT_REDIRECT,
    ACT_STALL,
    ACT_HALT,
    ACT_RUN
  } fetch_act_e;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  // Resolve the control inputs: redirect > stall > halt > run.
  function automatic fetch_act_e select_act(input logic redirect, input logic stall,
                                            input logic halt);
    if (redirect)   return ACT_REDIRECT;
    else if (stall) return ACT_STALL;
    else if (halt)  return ACT_HALT;
    else            return ACT_RUN;
  endfunction

endpackage

// File: rtl/if_fetch_pc_reg.sv
// Program counter for the fetch stage: PC register, +4 incrementer,
// redirect/stall/halt selection and the registered ROM chip enable.
// fetch_o flags the cycles in which the current ROM word is consumed.
module pc_reg
  import if_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            halt_i,
  output logic [XLEN-1:0] pc_o,
  output logic            ce_o,
  output logic            fetch_o
);

  fetch_act_e      act;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            ce_q, ce_d;

  assign act     = select_act(redirect_i, stall_i, halt_i);
  assign fetch_o = (act == ACT_RUN) && ce_q;
  assign pc_o    = pc_q;
  assign ce_o    = ce_q;

  // Next PC and chip enable from the resolved action.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    pc_d = pc_q;
    ce_d = ce_q;
    unique case (act)
      ACT_REDIRECT: begin
        pc_d = word_align(redirect_pc_i);
        ce_d = ~halt_i;
      end
      ACT_STALL: ;
      ACT_HALT:  ce_d = 1'b0;
      ACT_RUN: begin
        ce_d = 1'b1;
        // Wraps modulo 2^XLEN; the ROM aliases the high bits.
        if (ce_q) pc_d = pc_q + XLEN'(4);
      end
      default: ;
    endcase
  end

  // PC and chip-enable state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge values, independent of block ordering.
    if (!rst_n_i) begin
      pc_q <= RESET_PC;
      ce_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ce_q <= ce_d;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch initiator for the t1 core. Drives the combinational ROM
// (ce_o/addr_o) through pc_reg and registers the returned word with its PC
// into the IF/ID pipeline register.
// Optional feature: define IF_MISALIGN_CHK_EN to pulse misalign_o when a
// redirect target is not word aligned; otherwise misalign_o is tied to 0.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            halt_i,
  output logic            ce_o,
  output logic [XLEN-1:0] addr_o,
  input  logic [XLEN-1:0] inst_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_inst_o,
  output logic            id_valid_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] pc;
  logic            fetch;

  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_inst_q, id_inst_d;
  logic            id_valid_q, id_valid_d;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .halt_i       (halt_i),
    .pc_o         (pc),
    .ce_o         (ce_o),
    .fetch_o      (fetch)
  );

  assign addr_o     = pc;
  assign id_pc_o    = id_pc_q;
  assign id_inst_o  = id_inst_q;
  assign id_valid_o = id_valid_q;

  // IF/ID next state: capture on fetch, hold on stall, otherwise insert a
  // bubble (redirect squash, halt, or chip enable not yet up).
  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (fetch) begin
      id_pc_d    = pc;
      id_inst_d  = inst_i;
      id_valid_d = 1'b1;
    end else if (redirect_i || !stall_i) begin
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      id_pc_q    <= '0;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
    end else begin
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

`ifdef IF_MISALIGN_CHK_EN
  logic misalign_q;

  assign misalign_o = misalign_q;

  // One-cycle pulse, aligned with the PC update, for a misaligned target.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) misalign_q <= 1'b0;
    else          misalign_q <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a stimulus process drives control inputs
// each cycle and pushes the expected post-edge outputs of a behavioural model
// into a queue; a monitor process pops and compares after every rising edge.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        halt_i = 1'b0;
  logic        ce_o;
  logic [31:0] addr_o;
  logic [31:0] inst_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic        misalign_o;

  if_fetch dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .halt_i       (halt_i),
    .ce_o         (ce_o),
    .addr_o       (addr_o),
    .inst_i       (inst_i),
    .id_pc_o      (id_pc_o),
    .id_inst_o    (id_inst_o),
    .id_valid_o   (id_valid_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  // Combinational ROM: distinct word per address, fixed words at 0x0/0x4.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign inst_i = ce_o ? rom(addr_o) : 32'h0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the fetch stage.
  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic [31:0] idpc;
    logic [31:0] inst;
    logic        valid;
    logic        mis;
  } exp_t;

  exp_t m;
  exp_t sb[$];
  bit   mon_en = 1'b0;

  task automatic model_reset();
    m.ce = 1'b0; m.addr = 32'h0; m.idpc = 32'h0;
    m.inst = NOP; m.valid = 1'b0; m.mis = 1'b0;
  endtask

  // Apply inputs now (just after a falling edge) and predict post-edge state.
  task automatic drive(input bit st, input bit rd, input logic [31:0] rpc, input bit hl);
    stall_i = st; redirect_i = rd; redirect_pc_i = rpc; halt_i = hl;
    m.mis = 1'b0;
    if (rd) begin
      m.addr  = rpc & 32'hFFFF_FFFC;
      m.valid = 1'b0;
      m.inst  = NOP;
      m.ce    = !hl;
`ifdef IF_MISALIGN_CHK_EN
      m.mis   = (rpc % 4) != 0;
`endif
    end else if (st) begin
      // everything holds
    end else if (hl) begin
      m.ce = 1'b0; m.valid = 1'b0; m.inst = NOP;
    end else if (m.ce) begin
      m.idpc  = m.addr;
      m.inst  = rom(m.addr);
      m.valid = 1'b1;
      m.addr  = m.addr + 32'd4;
    end else begin
      m.ce = 1'b1; m.valid = 1'b0; m.inst = NOP;
    end
    sb.push_back(m);
  endtask

  task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc, input bit hl);
    @(negedge clk_i);
    drive(st, rd, rpc, hl);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ce"},       32'(ce_o),       32'h0);
    check({tag, " addr"},     addr_o,          32'h0);
    check({tag, " id_pc"},    id_pc_o,         32'h0);
    check({tag, " id_inst"},  id_inst_o,       NOP);
    check({tag, " id_valid"}, 32'(id_valid_o), 32'h0);
    check({tag, " misalign"}, 32'(misalign_o), 32'h0);
  endtask

  // Monitor: compare DUT outputs against the next expectation after each edge.
  always @(posedge clk_i) begin
    #1;
    if (mon_en) begin
      if (sb.size() == 0) begin
        check("scoreboard underflow", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ce_o",       32'(ce_o),       32'(e.ce));
        check("addr_o",     addr_o,          e.addr);
        check("id_pc_o",    id_pc_o,         e.idpc);
        check("id_inst_o",  id_inst_o,       e.inst);
        check("id_valid_o", 32'(id_valid_o), 32'(e.valid));
        check("misalign_o", 32'(misalign_o), 32'(e.mis));
      end
    end
  end

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bit          st, rd, hl;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 99) < 20);
      rd  = ($urandom_range(0, 99) < 10);
      hl  = ($urandom_range(0, 99) < 10);
      rpc = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255)) : $urandom;
      cycle(st, rd, rpc, hl);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("reset");
    rst_n_i = 1'b1;
    drive(0, 0, 0, 0);
    mon_en = 1'b1;

    // Directed: start-up fetch, stall, redirects, misaligned target, halt, wrap.
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 1, 32'h20, 0);
    cycle(0, 1, 32'h20, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 1, 32'h40, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 32'h22, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 32'h10, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 32'hFFFF_FFFC, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 32'h8, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    random_cycles(1500);

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk_i);
    mon_en = 1'b0;
    stall_i = 0; redirect_i = 0; halt_i = 0;
    #2 rst_n_i = 1'b0;
    #1 check_reset_outputs("async reset");
    @(posedge clk_i);
    #1 check_reset_outputs("held reset");
    @(negedge clk_i);
    model_reset();
    rst_n_i = 1'b1;
    drive(0, 0, 0, 0);
    mon_en = 1'b1;

    random_cycles(1500);

    @(posedge clk_i);
    #2;
    check("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch initiator for the t1 core. Owns the program counter, drives the chip-enable and address inputs of the combinational instruction ROM, and registers the returned word into an IF/ID pipeline register with its PC and a valid bit. Supports pipeline stall, control-flow redirect and halt. Feeds the decode stage directly.

## Interface
- XLEN, 32, datapath and address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID when invalid
- clk_i  input  1  single clock, all state on rising edge
- rst_n_i  input  1  asynchronous, active-low reset
- stall_i  input  1  hold PC and IF/ID contents this cycle
- redirect_i  input  1  load redirect_pc_i into PC; squash the word fetched this cycle
- redirect_pc_i  input  XLEN  redirect target
- halt_i  input  1  stop fetching (level)
- ce_o  output  1  ROM chip enable
- addr_o  output  XLEN  ROM byte address (= current PC)
- inst_i  input  XLEN  ROM data, valid combinationally in the same cycle as addr_o; big-endian word, 0 when ce_o=0
- id_pc_o  output  XLEN  PC of instruction in IF/ID
- id_inst_o  output  XLEN  instruction in IF/ID
- id_valid_o  output  1  IF/ID holds a real instruction
- misalign_o  output  1  redirect target misaligned (see Configuration)

## Operation
- Reset values: PC=RESET_PC, ce_o=0, addr_o=RESET_PC, id_pc_o=0, id_inst_o=NOP_INST, id_valid_o=0, misalign_o=0.
- ce_o is registered: first rising edge after rst_n_i release sets ce_o=1 (unless halt_i); no fetch is captured while ce_o=0.
- addr_o = PC continuously; PC is always word-aligned (bits [1:0]=0).
- Per cycle, priority redirect_i > stall_i > halt_i > normal:
  - redirect_i=1: PC<=redirect_pc_i with [1:0] forced to 00; id_valid_o<=0, id_inst_o<=NOP_INST, id_pc_o unchanged. Applies even when stall_i=1 or halt_i=1.
  - stall_i=1: PC, ce_o and all id_* hold.
  - halt_i=1: ce_o<=0, PC holds, id_valid_o<=0, id_inst_o<=NOP_INST. Deasserting halt_i sets ce_o<=1 next edge; fetch resumes at held PC.
  - normal with ce_o=1: id_pc_o<=PC, id_inst_o<=inst_i, id_valid_o<=1, PC<=PC+4.
- PC+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0). No bounds check; ROM aliases high bits.
- Reset asserted mid-operation: all state returns to reset values asynchronously; the in-flight word is lost.

## Timing
- Fetch latency: instruction at PC appears on id_inst_o one edge after PC is presented on addr_o.
- Throughput: one instruction per cycle when not stalled.
- Redirect penalty: one bubble; target word appears on id_* two edges after redirect_i is sampled.
- Stall takes effect at the edge it is sampled; release resumes on the next edge with no lost or duplicated word.
- misalign_o is a registered one-cycle pulse aligned with the PC update.

## Configuration
- IF_MISALIGN_CHK_EN defined: misalign_o<=1 for one cycle when redirect_i=1 and redirect_pc_i[1:0]!=0; the target is still truncated to word alignment.
- Not defined: misalign_o tied to 0; misaligned targets are silently truncated.

## Structure
- Shared package: XLEN, RESET_PC default, NOP_INST constant, word-align helper.
- One sub-module: pc_reg (PC register, +4 incrementer, redirect/stall/halt mux, ce_o flop); if_fetch adds the IF/ID register and misalign logic.

## Test plan
- Reset release, ROM words 0x00500093,0x00A00113 at 0x0,0x4 -> ce_o rises one edge after release; id_inst_o=0x00500093/id_pc_o=0x0 then 0x00A00113/0x4, id_valid_o=1.
- stall_i high 3 cycles while id_pc_o=0x4 -> id_* and addr_o hold 3 cycles; next edge id_pc_o=0x8, no skip or duplicate.
- redirect_i with target 0x20 while addr_o=0x8 -> next edge id_valid_o=0, addr_o=0x20; following edge id_pc_o=0x20, valid=1.
- redirect_i and stall_i together, target 0x40 -> redirect wins: addr_o=0x40, id_valid_o=0.
- With IF_MISALIGN_CHK_EN, redirect to 0x22 -> addr_o=0x20, misalign_o pulses one cycle; without macro misalign_o stays 0.
- halt_i asserted at PC=0x10, held 2 cycles -> ce_o=0, id_valid_o=0; after release ce_o=1 next edge, fetch resumes at 0x10; also PC 0xFFFFFFFC advances to 0x0.
